// File: rtl/fft_input_pkg.sv
// Shared types and helpers for the FFT frame input gate.
// Optional build macro used by the users of this package: FFT_FRAME_INPUT_BITREV_EN.
package fft_input_pkg;

  // Widest frame exponent any instance may use; sizes the bitrev helper.
  localparam int MAX_LOG2_N = 10;

  // Read-side state machine encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } rd_state_e;

  // Number of samples in one frame.
  function automatic int frame_len(input int log2_n);
    return 1 << log2_n;
  endfunction

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [MAX_LOG2_N-1:0] bitrev(input logic [MAX_LOG2_N-1:0] v,
                                                   input int w);
    logic [MAX_LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2_N; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Two-bank sample store: 2*FRAME_LEN words, one write port, one registered
// read port. Address is {bank, idx}. The read register only loads when
// rd_en is high, so it doubles as the output prefetch/hold register.
module fft_bank_ram
  import fft_input_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LOG2_N:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [LOG2_N:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 * frame_len(LOG2_N);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Storage write port; contents are not reset, validity lives in the bank flags.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register loads on request, otherwise holds for a stalled consumer.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Read register with reset so the output sample reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_input.sv
// FFT front-end input gate: collects a serial sample stream into frames of
// 2^LOG2_N samples, ping-pongs them across two banks and drains each frame
// to the FFT core with index / start / end markers.
// Build macro FFT_FRAME_INPUT_BITREV_EN: read frames out in bit-reversed
// address order (out_idx still counts output position).
//
// Handshake: a transfer happens on a rising edge where valid (req) and ready
// (ans) are both high. Once out_req is raised it stays high and out_data,
// out_idx, out_sop, out_eop stay stable until the transfer edge. in_ans never
// looks at in_req.
module fft_frame_input
  import fft_input_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_req,
  output logic              in_ans,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_req,
  input  logic              out_ans,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2_N-1:0] out_idx,
  output logic              out_sop,
  output logic              out_eop,
  output logic              ovf
);

  localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};

  // Write side state
  logic              wr_bank_q, wr_bank_d;
  logic [LOG2_N-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]        full_q, full_d;
  logic              ovf_q, ovf_d;

  // Read side state and registered outputs
  rd_state_e         state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2_N-1:0] rd_cnt_q, rd_cnt_d;
  logic              out_req_q, out_req_d;
  logic [LOG2_N-1:0] out_idx_q, out_idx_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;

  logic              in_fire, out_fire, wr_last, rd_last, rd_done;
  logic              ram_rd_en;
  logic [LOG2_N-1:0] rd_pos, rd_addr_idx;

  assign in_ans   = en && !full_q[wr_bank_q];
  assign in_fire  = in_req && in_ans;
  assign out_fire = out_req_q && out_ans;
  assign wr_last  = (wr_cnt_q == LAST_IDX);
  assign rd_last  = (rd_cnt_q == LAST_IDX);
  assign rd_done  = (state_q == SHOW) && out_fire && rd_last;

  // Write pointer: fill the current bank, hop to the other bank after the last word.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (in_fire) begin
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // Bank full flags and sticky overflow. Read frees rd_bank, write fills
  // wr_bank; the two are never the same bank on one edge.
  always_comb begin
    full_d = full_q;
    if (rd_done)           full_d[rd_bank_q] = 1'b0;
    if (in_fire && wr_last) full_d[wr_bank_q] = 1'b1;
    ovf_d = ovf_q | (en & in_req & full_q[0] & full_q[1]);
  end

  // Read FSM: IDLE waits for a full bank, LOAD primes the RAM read register
  // with sample 0, SHOW presents samples and prefetches the next on each transfer.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    out_req_d = out_req_q;
    out_idx_d = out_idx_q;
    out_sop_d = out_sop_q;
    out_eop_d = out_eop_q;
    ram_rd_en = 1'b0;
    rd_pos    = '0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = LOAD;
      end
      LOAD: begin
        ram_rd_en = 1'b1;
        rd_pos    = '0;
        state_d   = SHOW;
        out_req_d = 1'b1;
        out_idx_d = '0;
        out_sop_d = 1'b1;
        out_eop_d = 1'b0;
      end
      SHOW: begin
        if (out_fire) begin
          if (rd_last) begin
            state_d   = IDLE;
            rd_cnt_d  = '0;
            rd_bank_d = ~rd_bank_q;
            out_req_d = 1'b0;
            out_idx_d = '0;
            out_sop_d = 1'b0;
            out_eop_d = 1'b0;
          end else begin
            rd_pos    = rd_cnt_q + 1'b1;
            rd_cnt_d  = rd_pos;
            ram_rd_en = 1'b1;
            out_idx_d = rd_pos;
            out_sop_d = 1'b0;
            out_eop_d = (rd_pos == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FFT_FRAME_INPUT_BITREV_EN
  // Bit-reversed storage address for a decimation-in-time core.
  assign rd_addr_idx = LOG2_N'(bitrev(MAX_LOG2_N'(rd_pos), LOG2_N));
`else
  // Natural-order readout.
  assign rd_addr_idx = rd_pos;
`endif

  // All control state, including discard of any partial or full frame on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      full_q    <= 2'b00;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      out_req_q <= 1'b0;
      out_idx_q <= '0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      out_req_q <= out_req_d;
      out_idx_q <= out_idx_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
    end
  end

  fft_bank_ram #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_fire),
    .wr_addr ({wr_bank_q, wr_cnt_q}),
    .wr_data (in_data),
    .rd_en   (ram_rd_en),
    .rd_addr ({rd_bank_q, rd_addr_idx}),
    .rd_data (out_data)
  );

  assign out_req = out_req_q;
  assign out_idx = out_idx_q;
  assign out_sop = out_sop_q;
  assign out_eop = out_eop_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fft_frame_input.sv
// Bench for fft_frame_input (LOG2_N=4, DATA_W=16). Honours
// FFT_FRAME_INPUT_BITREV_EN for the expected output order.
module tb_fft_frame_input;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 4;
  localparam int N      = 16;
`ifdef FFT_FRAME_INPUT_BITREV_EN
  localparam bit BITREV_ON = 1'b1;
`else
  localparam bit BITREV_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en, in_req, in_ans, out_req, out_ans, out_sop, out_eop, ovf;
  logic [DATA_W-1:0] in_data, out_data;
  logic [LOG2_N-1:0] out_idx;

  fft_frame_input #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_req(in_req), .in_ans(in_ans), .in_data(in_data),
    .out_req(out_req), .out_ans(out_ans), .out_data(out_data),
    .out_idx(out_idx), .out_sop(out_sop), .out_eop(out_eop), .ovf(ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] part_q[$];   // accepted samples of the frame being filled
  logic [DATA_W-1:0] exp_q[$];    // expected output beats, in output order
  logic [DATA_W-1:0] obs_q[$];    // observed output beats (for sequence checks)
  int  frames_held = 0;           // completed frames not yet fully drained
  int  out_beat    = 0;
  bit  ovf_m       = 1'b0;
  int  cyc         = 0;
  int  acc_cnt     = 0;
  int  done_edge   = 0;
  int  rise_edge   = 0;
  bit  prev_req    = 1'b0;

  function automatic int rev_bits(input int p);
    int r = 0;
    for (int i = 0; i < LOG2_N; i++)
      if (((p >> i) & 1) != 0) r |= 1 << (LOG2_N - 1 - i);
    return r;
  endfunction

  // Evaluated mid-cycle: decides what the coming rising edge will transfer.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    cyc++;
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      frames_held = 0;
      out_beat    = 0;
      ovf_m       = 1'b0;
      prev_req    = 1'b0;
    end else begin
      check("in_ans", in_ans, en && (frames_held < 2));
      check("ovf", ovf, ovf_m);
      if (en && in_req && frames_held == 2) ovf_m = 1'b1;
      if (out_req && !prev_req) rise_edge = cyc;
      prev_req = out_req;
      if (out_req && out_ans) begin
        if (exp_q.size() == 0) begin
          check("out_req_no_frame", out_req, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("out_idx", out_idx, out_beat);
          check("out_sop", out_sop, out_beat == 0);
          check("out_eop", out_eop, out_beat == N - 1);
          obs_q.push_back(out_data);
          out_beat++;
          if (out_beat == N) begin
            out_beat = 0;
            frames_held--;
          end
        end
      end
      if (in_req && in_ans) begin
        acc_cnt++;
        part_q.push_back(in_data);
        if (part_q.size() == N) begin
          for (int p = 0; p < N; p++)
            exp_q.push_back(part_q[BITREV_ON ? rev_bits(p) : p]);
          part_q.delete();
          frames_held++;
          done_edge = cyc + 1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int ans_mode = 0;   // 0: ready, 1: stalled, 2: 1,0,0,1 pattern, 3: random
  int ans_ph   = 0;

  initial begin
    out_ans = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ans_mode)
        0:       out_ans = 1'b1;
        1:       out_ans = 1'b0;
        2: begin out_ans = ((ans_ph % 4) == 0) || ((ans_ph % 4) == 3); ans_ph++; end
        default: out_ans = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic do_reset(input int n);
    en = 1'b0; in_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_req"}, out_req, 0);
    check({tag, "_out_sop"}, out_sop, 0);
    check({tag, "_out_eop"}, out_eop, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_in_ans"}, in_ans, 0);
  endtask

  task automatic send_one(input logic [DATA_W-1:0] v);
    bit ok = 1'b0;
    in_req = 1'b1;
    in_data = v;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = in_ans;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic send_frame(input int n, input bit seq, input int base, input int gap);
    for (int i = 0; i < n; i++) begin
      send_one(seq ? DATA_W'(base + i) : DATA_W'($urandom));
      if (gap > 0) begin
        in_req = 1'b0;
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      end
    end
    in_req = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_out_req", out_req, 0);
  endtask

  task automatic check_seq(input string tag, input int base);
    check({tag, "_len"}, obs_q.size(), N);
    for (int i = 0; i < N && i < obs_q.size(); i++)
      check(tag, obs_q[i], base + (BITREV_ON ? rev_bits(i) : i));
  endtask

  // ---------------- tests ----------------
  int acc0;
  int br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    en = 1'b0; in_req = 1'b0; in_data = '0;

    // Reset, then a reset in the middle of a frame
    do_reset(3);
    check_reset_outputs("rst0");
    ans_mode = 0;
    en = 1'b1;
    send_frame(5, 1'b0, 0, 0);
    do_reset(3);
    check_reset_outputs("rst_mid");
    en = 1'b1;
    obs_q.delete();
    send_frame(N, 1'b1, 16'h0200, 0);
    wait_drain(500);
    check_seq("rst_frame", 16'h0200);

    // Single counting frame: latency, order, markers
    obs_q.delete();
    send_frame(N, 1'b1, 0, 0);
    wait_drain(500);
    check("latency_edges", rise_edge - done_edge, 2);
    check("single_len", obs_q.size(), N);
    for (int i = 0; i < N && i < obs_q.size(); i++)
      check("single_seq", obs_q[i], BITREV_ON ? br_tab[i] : i);

    // Backpressure with the 1,0,0,1 pattern, then random ready and gaps
    ans_ph = 0;
    ans_mode = 2;
    send_frame(2 * N, 1'b0, 0, 2);
    wait_drain(3000);
    ans_mode = 3;
    send_frame(3 * N, 1'b0, 0, 3);
    wait_drain(3000);

    // Ping-pong fill with downstream stalled, overflow, then release
    ans_mode = 1;
    @(posedge clk); #1;
    acc0 = acc_cnt;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_req = 1'b1;
      in_data = DATA_W'(16'h0300 + i);
      @(posedge clk); #1;
    end
    in_req = 1'b0;
    check("pp_accepts", acc_cnt - acc0, 32);
    check("pp_ovf_set", ovf, 1);
    obs_q.delete();
    ans_mode = 0;
    wait_drain(500);
    check("pp_obs_len", obs_q.size(), 2 * N);
    for (int i = 0; i < 2 * N && i < obs_q.size(); i++)
      check("pp_seq", obs_q[i],
            16'h0300 + (i / N) * N + (BITREV_ON ? rev_bits(i % N) : (i % N)));
    check("pp_ovf_sticky", ovf, 1);

    // Enable gating mid-frame
    do_reset(2);
    check_reset_outputs("rst_en");
    en = 1'b1;
    acc0 = acc_cnt;
    obs_q.delete();
    send_frame(7, 1'b1, 16'h0100, 0);
    en = 1'b0;
    in_req = 1'b1;
    in_data = 16'hdead;
    repeat (10) begin @(posedge clk); #1; end
    in_req = 1'b0;
    check("en_accepts", acc_cnt - acc0, 7);
    check("en_no_ovf", ovf, 0);
    check("en_no_out", out_req, 0);
    en = 1'b1;
    send_frame(9, 1'b1, 16'h0107, 0);
    wait_drain(500);
    check_seq("en_frame", 16'h0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_input.md
Name: fft_frame_input

Overview:
- Parametrised successor to the FFT front-end input gate. Accepts a serial sample stream over a req/ans handshake, gated by `en`, and assembles samples into frames of 2^LOG2_N.
- Frames are ping-pong buffered across two banks, so one frame can be filled while the previous one is drained.
- Drained frames are presented to the FFT core with sample index, start-of-frame and end-of-frame markers.
- Sits between the serial input device and the FFT core.

Parameters:
- DATA_W, 16, sample width in bits (complex packing is the caller's choice).
- LOG2_N, 4, log2 of frame length; FRAME_LEN = 2^LOG2_N; legal range 2..10.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  input enable; 0 blocks new input transfers only.
- in_req  in  1  upstream sample valid.
- in_ans  out  1  ready to accept a sample.
- in_data  in  DATA_W  upstream sample.
- out_req  out  1  output sample valid.
- out_ans  in  1  downstream ready.
- out_data  out  DATA_W  output sample.
- out_idx  out  LOG2_N  position of out_data in the frame (natural order).
- out_sop  out  1  high with index 0.
- out_eop  out  1  high with index FRAME_LEN-1.
- ovf  out  1  sticky: input was offered while both banks were full.

Behaviour:
- Transfer rules:
  - Input transfer occurs on any edge where in_req && in_ans.
  - Output transfer occurs on any edge where out_req && out_ans.
- Reset values: on rst=1 at an edge, all outputs are 0, both banks are marked empty, write/read pointers are 0, bank selects are 0 and ovf is 0. This holds mid-frame: any partial or full frames are discarded.
- in_ans = en && (write bank not full). It is combinational from registered state and en only, never from in_req.
- Write side:
  - wr_cnt counts 0..FRAME_LEN-1. Each input transfer writes in_data to wr_bank[wr_cnt].
  - On the transfer with wr_cnt = FRAME_LEN-1: mark wr_bank full, toggle wr_bank, and set wr_cnt to 0.
  - If the new wr_bank is still full, in_ans drops on the next cycle.
- en=0 mid-frame: the partial frame is held and wr_cnt is retained; filling resumes when en returns to 1. No padding is added.
- Read side state machine:
  - IDLE -> LOAD when rd_bank is full.
  - LOAD (1 cycle, RAM read): -> SHOW.
  - SHOW: out_req=1.
    - While out_ans=0: hold out_req and all out_* stable, and do not advance.
    - On transfer with rd_cnt < FRAME_LEN-1: present the next sample in the next cycle with no bubble (prefetch register).
    - On transfer with rd_cnt = FRAME_LEN-1: mark rd_bank empty, toggle rd_bank, go to IDLE.
  - Throughput: one sample per clock when out_ans is held high.
- Latency: first out_req of a frame rises 2 edges after the edge that accepted the frame's last sample, provided the read side was IDLE.
- Back-to-back frames: an IDLE->LOAD gap of 2 cycles between frames is allowed.
- Simultaneous events: a bank becomes fillable on the edge after its read completes. The same edge never both frees and writes a bank, so there is no write/read hazard on one bank.
- ovf: set on any edge with en && in_req && both banks full. It is cleared only by rst.
- Widths: wr_cnt and rd_cnt are LOG2_N bits and wrap naturally. There is no arithmetic on data; samples pass bit-exact.

Optional Feature:
- Macro: FFT_FRAME_INPUT_BITREV_EN.
- Defined: the read address is the bit-reverse of rd_cnt, so out_data emerges in bit-reversed order for a DIT core. out_idx still reports rd_cnt (output position), so sop/eop are unchanged.
- Undefined: natural-order readout, and no bit-reverse logic is synthesised.

Decomposition:
- Package fft_input_pkg contains:
  - FRAME_LEN function of LOG2_N.
  - Read-state enum {IDLE, LOAD, SHOW}.
  - bitrev function.
- Sub-module fft_bank_ram: 2*FRAME_LEN x DATA_W simple dual-port RAM, one write port and one registered read port, address = {bank, idx}.

Test Plan:
- Reset/idle: assert rst for 3 cycles mid-frame after 5 writes -> all outputs 0, ovf=0; a following frame of 16 samples emerges intact with no residue of the first 5.
- Single frame, LOG2_N=4: send 0x0000..0x000F with out_ans=1 -> out_req rises 2 edges after the last accept; 16 consecutive beats; idx 0..15; sop on 0x0000, eop on 0x000F.
- Backpressure: out_ans toggles 1,0,0,1 repeatedly -> data and idx stay stable while stalled; there are no duplicates or drops, and the sequence equals the input sequence.
- Ping-pong fill and ovf: hold out_ans=0 and drive 40 samples with in_req=1 -> in_ans falls after exactly 32 accepts and ovf sets the next cycle; release out_ans -> frames 0..15 then 16..31 appear in order and ovf stays 1.
- en gating: accept 7 samples, then hold en=0 for 10 cycles with in_req=1 -> no accepts and no ovf; re-enable and send 9 more -> one correct 16-sample frame.
- Bitrev build with the macro defined: input 0..15 -> out_data sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with idx 0..15.
